// File: rtl/updown_modn_counter.sv
// Synchronous up/down counter made of DIGITS cascaded modulo-MODULUS digits, all on one clock edge.
// Optional saturating build: define UPDOWN_MODN_SAT_EN to hold at the terminal count instead of wrapping.
module updown_modn_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10,
  parameter int DIGITS  = 2
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      m,
  input  logic                      load,
  input  logic [DIGITS*WIDTH-1:0]   load_value,
  output logic [DIGITS*WIDTH-1:0]   q,
  output logic                      tc,
  output logic                      wrap
);

  localparam logic [WIDTH-1:0] DMAX = WIDTH'(MODULUS - 1);

  // up_chain[i] / dn_chain[i]: every digit below i sits at its up / down limit.
  logic [DIGITS:0]             up_chain;
  logic [DIGITS:0]             dn_chain;
  logic [DIGITS*WIDTH-1:0]     q_step;
  logic [DIGITS*WIDTH-1:0]     q_load;

  assign up_chain[0] = 1'b1;
  assign dn_chain[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] lv;
    logic [WIDTH-1:0] step;

    assign d  = q[i*WIDTH +: WIDTH];
    assign lv = load_value[i*WIDTH +: WIDTH];

    assign up_chain[i+1] = up_chain[i] & (d == DMAX);
    assign dn_chain[i+1] = dn_chain[i] & (d == '0);

    assign q_load[i*WIDTH +: WIDTH] = (lv > DMAX) ? DMAX : lv;

    always_comb begin
      step = d;
      if (!m && up_chain[i]) begin
        step = (d == DMAX) ? '0 : d + WIDTH'(1);
      end else if (m && dn_chain[i]) begin
        step = (d == '0) ? DMAX : d - WIDTH'(1);
      end
    end

    assign q_step[i*WIDTH +: WIDTH] = step;
  end

  assign tc = m ? dn_chain[DIGITS] : up_chain[DIGITS];

  always_ff @(posedge clock) begin
    if (clear) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= q_load;
      wrap <= 1'b0;
    end else if (enable) begin
`ifdef UPDOWN_MODN_SAT_EN
      if (!tc) begin
        q <= q_step;
      end
      wrap <= 1'b0;
`else
      q    <= q_step;
      wrap <= tc;
`endif
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_modn_counter.sv
// Directed-vector bench for updown_modn_counter; default build checks the 2-digit decade
// counter, the UPDOWN_MODN_SAT_EN build checks a saturating 1-digit hex counter.
module tb_updown_modn_counter;

`ifdef UPDOWN_MODN_SAT_EN
  localparam int MODN = 16;
  localparam int NDIG = 1;
`else
  localparam int MODN = 10;
  localparam int NDIG = 2;
`endif
  localparam int QW = 4 * NDIG;

  logic          clock;
  logic          clear;
  logic          enable;
  logic          m;
  logic          load;
  logic [QW-1:0] load_value;
  logic [QW-1:0] q;
  logic          tc;
  logic          wrap;

  int n_vec    = 0;
  int n_miscmp = 0;

  updown_modn_counter #(.WIDTH(4), .MODULUS(MODN), .DIGITS(NDIG)) dut (
    .clock      (clock),
    .clear      (clear),
    .enable     (enable),
    .m          (m),
    .load       (load),
    .load_value (load_value),
    .q          (q),
    .tc         (tc),
    .wrap       (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    clear = 1'b1; enable = 1'b0; m = 1'b0; load = 1'b0; load_value = '0;
    tick();
    clear = 1'b0;
    chk_vec("reset_q", 32'(q), 32'h0);
    chk_vec("reset_wrap", 32'(wrap), 32'h0);
    chk_vec("reset_tc", 32'(tc), 32'h0);

`ifdef UPDOWN_MODN_SAT_EN
    load = 1'b1; load_value = 4'hF; enable = 1'b1; m = 1'b0;
    tick();
    load = 1'b0;
    chk_vec("sat_load_q", 32'(q), 32'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_vec("sat_up_hold_q", 32'(q), 32'hF);
      chk_vec("sat_up_hold_wrap", 32'(wrap), 32'h0);
      chk_vec("sat_up_hold_tc", 32'(tc), 32'h1);
    end
    m = 1'b1;
    #1;
    chk_vec("sat_tc_follows_m", 32'(tc), 32'h0);
    for (int k = 14; k >= 0; k--) begin
      tick();
      chk_vec("sat_down_q", 32'(q), 32'(k));
      chk_vec("sat_down_wrap", 32'(wrap), 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_vec("sat_down_hold_q", 32'(q), 32'h0);
      chk_vec("sat_down_hold_wrap", 32'(wrap), 32'h0);
      chk_vec("sat_down_hold_tc", 32'(tc), 32'h1);
    end
`else
    // count up through the whole 00..99 range and wrap
    enable = 1'b1; m = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk_vec("up_q", 32'(q), 32'(bcd(k % 100)));
      chk_vec("up_tc", 32'(tc), 32'((k % 100) == 99));
      chk_vec("up_wrap", 32'(wrap), 32'(k == 100));
    end
    enable = 1'b0;
    tick();
    chk_vec("wrap_drop_q", 32'(q), 32'h00);
    chk_vec("wrap_drop", 32'(wrap), 32'h0);

    // count down from 10 through 00 to 99
    load = 1'b1; load_value = 8'h10;
    tick();
    load = 1'b0;
    chk_vec("load10_q", 32'(q), 32'h10);
    enable = 1'b1; m = 1'b1;
    for (int k = 9; k >= 0; k--) begin
      tick();
      chk_vec("down_q", 32'(q), 32'(bcd(k)));
      chk_vec("down_tc", 32'(tc), 32'(k == 0));
      chk_vec("down_wrap", 32'(wrap), 32'h0);
    end
    tick();
    chk_vec("down_wrap_q", 32'(q), 32'h99);
    chk_vec("down_wrap_pulse", 32'(wrap), 32'h1);
    chk_vec("down_wrap_tc", 32'(tc), 32'h0);

    // tc follows m combinationally
    enable = 1'b0; load = 1'b1; load_value = 8'h00; m = 1'b0;
    tick();
    load = 1'b0;
    chk_vec("tc_m0_at00", 32'(tc), 32'h0);
    m = 1'b1;
    #1;
    chk_vec("tc_m1_at00", 32'(tc), 32'h1);

    // mode toggle at 05 gives no skip
    load = 1'b1; load_value = 8'h05;
    tick();
    load = 1'b0;
    chk_vec("load05_q", 32'(q), 32'h05);
    enable = 1'b1;
    tick();
    chk_vec("toggle_down_q", 32'(q), 32'h04);
    m = 1'b0;
    tick();
    chk_vec("toggle_up_q", 32'(q), 32'h05);
    tick();
    chk_vec("toggle_up2_q", 32'(q), 32'h06);

    // load clamps and wins over enable
    load = 1'b1; load_value = 8'h3F; enable = 1'b1; m = 1'b0;
    tick();
    load = 1'b0;
    chk_vec("clamp_q", 32'(q), 32'h39);
    chk_vec("clamp_wrap", 32'(wrap), 32'h0);
    tick();
    chk_vec("clamp_next_q", 32'(q), 32'h40);

    load = 1'b1; load_value = 8'hA9;
    tick();
    load = 1'b0;
    chk_vec("clamp_hi_q", 32'(q), 32'h99);

    // clear beats load and enable mid-count
    load = 1'b1; load_value = 8'h57; enable = 1'b0;
    tick();
    chk_vec("load57_q", 32'(q), 32'h57);
    clear = 1'b1; load = 1'b1; load_value = 8'h22; enable = 1'b1;
    tick();
    clear = 1'b0; load = 1'b0; enable = 1'b0;
    chk_vec("clear_pri_q", 32'(q), 32'h00);
    chk_vec("clear_pri_wrap", 32'(wrap), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_vec("hold_q", 32'(q), 32'h00);
      chk_vec("hold_wrap", 32'(wrap), 32'h0);
      chk_vec("hold_tc", 32'(tc), 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
